// File: rtl/softmax_pkg.sv
// Shared types and sizing helpers for the softmax sequencing controller.
package softmax_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT,
    DRAIN
  } state_e;

  localparam int DEF_N         = 10;
  localparam int DEF_WORD_SIZE = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/softmax_word_serializer.sv
// Output buffer and word-by-word valid/ready drain of the softmax result.
// SOFTMAX_ARGMAX_EN adds a running signed argmax over the drained words.
module softmax_word_serializer
  import softmax_pkg::*;
#(
  parameter  int N         = DEF_N,
  parameter  int WORD_SIZE = DEF_WORD_SIZE,
  localparam int IW        = idx_w(N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         capture,
  input  logic [N-1:0][WORD_SIZE-1:0]  sm_dataOut,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [WORD_SIZE-1:0]         out_data,
  output logic [IW-1:0]                out_index,
  output logic                         out_last,
  output logic                         done
`ifdef SOFTMAX_ARGMAX_EN
  ,
  output logic [IW-1:0]                argmax_idx,
  output logic                         argmax_valid
`endif
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [N-1:0][WORD_SIZE-1:0] obuf_q, obuf_d;
  logic [IW-1:0]               rd_idx_q, rd_idx_d;
  logic                        valid_q, valid_d;
  logic                        at_last, fire;

  assign at_last   = (rd_idx_q == LAST);
  assign fire      = valid_q && out_ready;
  assign done      = fire && at_last;
  assign out_valid = valid_q;
  assign out_data  = obuf_q[rd_idx_q];
  assign out_index = rd_idx_q;
  assign out_last  = valid_q && at_last;

  always_comb begin
    obuf_d   = obuf_q;
    rd_idx_d = rd_idx_q;
    valid_d  = valid_q;
    if (capture) begin
      obuf_d   = sm_dataOut;
      rd_idx_d = '0;
      valid_d  = 1'b1;
    end else if (fire) begin
      rd_idx_d = at_last ? '0 : rd_idx_q + 1'b1;
      valid_d  = !at_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obuf_q   <= '0;
      rd_idx_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      obuf_q   <= obuf_d;
      rd_idx_q <= rd_idx_d;
      valid_q  <= valid_d;
    end
  end

`ifdef SOFTMAX_ARGMAX_EN
  logic signed [WORD_SIZE-1:0] max_q, max_d, word;
  logic [IW-1:0]               best_q, best_d, am_q, am_d;
  logic                        amv_q, amv_d;

  // Strict greater-than keeps the first maximum on ties.
  always_comb begin
    word   = $signed(out_data);
    max_d  = max_q;
    best_d = best_q;
    am_d   = am_q;
    amv_d  = 1'b0;
    if (fire && (rd_idx_q == '0 || word > max_q)) begin
      max_d  = word;
      best_d = rd_idx_q;
    end
    if (done) begin
      am_d  = best_d;
      amv_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q  <= '0;
      best_q <= '0;
      am_q   <= '0;
      amv_q  <= 1'b0;
    end else begin
      max_q  <= max_d;
      best_q <= best_d;
      am_q   <= am_d;
      amv_q  <= amv_d;
    end
  end

  assign argmax_idx   = am_q;
  assign argmax_valid = amv_q;
`endif

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Frame fill, datapath latency wait and drain sequencing for softmax.
// Optional argmax outputs: define SOFTMAX_ARGMAX_EN.
module softmax_seq_ctrl
  import softmax_pkg::*;
#(
  parameter  int N         = DEF_N,
  parameter  int WORD_SIZE = DEF_WORD_SIZE,
  parameter  int LATENCY   = 6,
  localparam int IW        = idx_w(N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_SIZE-1:0]         in_data,
  input  logic                         in_last,
  output logic [N-1:0][WORD_SIZE-1:0]  sm_dataIn,
  input  logic [N-1:0][WORD_SIZE-1:0]  sm_dataOut,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_SIZE-1:0]         out_data,
  output logic [IW-1:0]                out_index,
  output logic                         out_last,
  output logic                         frame_err,
  output logic                         busy
`ifdef SOFTMAX_ARGMAX_EN
  ,
  output logic [IW-1:0]                argmax_idx,
  output logic                         argmax_valid
`endif
);

  localparam int            LW   = idx_w(LATENCY);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e                      state_q, state_d;
  logic [IW-1:0]               wr_idx_q, wr_idx_d;
  logic [LW-1:0]               lat_cnt_q, lat_cnt_d;
  logic [N-1:0][WORD_SIZE-1:0] frame_q, frame_d;
  logic                        err_q, err_d;
  logic                        capture, done, last_slot;

  assign last_slot = (wr_idx_q == LAST);
  assign in_ready  = (state_q == FILL);
  assign busy      = (state_q == WAIT) || (state_q == DRAIN);
  assign sm_dataIn = frame_q;
  assign frame_err = err_q;

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    lat_cnt_d = lat_cnt_q;
    frame_d   = frame_q;
    err_d     = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        if (in_valid) begin
          frame_d[wr_idx_q] = in_data;
          err_d = in_last ^ last_slot;
          if (last_slot) begin
            wr_idx_d  = '0;
            lat_cnt_d = LW'(LATENCY - 1);
            state_d   = WAIT;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          capture = 1'b1;
          state_d = DRAIN;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      DRAIN: if (done) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_idx_q  <= '0;
      lat_cnt_q <= '0;
      frame_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      lat_cnt_q <= lat_cnt_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
    end
  end

  softmax_word_serializer #(
    .N         (N),
    .WORD_SIZE (WORD_SIZE)
  ) u_ser (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture),
    .sm_dataOut   (sm_dataOut),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last),
    .done         (done)
`ifdef SOFTMAX_ARGMAX_EN
    ,
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
`endif
  );

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed bench for softmax_seq_ctrl with a pipelined datapath model.
// Argmax checks are compiled in with SOFTMAX_ARGMAX_EN.
module tb_softmax_seq_ctrl;

  localparam int N   = 10;
  localparam int WS  = 16;
  localparam int LAT = 6;
  localparam int IW  = $clog2(N);

  typedef logic [N-1:0][WS-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_last;
  logic [WS-1:0] in_data;
  vec_t          sm_dataIn, sm_dataOut;
  logic          out_valid, out_ready, out_last;
  logic [WS-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          frame_err, busy;
`ifdef SOFTMAX_ARGMAX_EN
  logic [IW-1:0] argmax_idx;
  logic          argmax_valid;
`endif

  softmax_seq_ctrl #(
    .N         (N),
    .WORD_SIZE (WS),
    .LATENCY   (LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .sm_dataIn    (sm_dataIn),
    .sm_dataOut   (sm_dataOut),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last),
    .frame_err    (frame_err),
    .busy         (busy)
`ifdef SOFTMAX_ARGMAX_EN
    ,
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
`endif
  );

  always #5 clk = ~clk;

  // Datapath model: word-wise +3 behind LAT-1 register stages, so the
  // vector that is stable after the final accept is valid LAT edges later.
  function automatic vec_t dp_f(input vec_t v);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = v[i] + WS'(3);
    return r;
  endfunction

  vec_t pipe [LAT-1];
  always @(posedge clk) begin
    pipe[0] <= dp_f(sm_dataIn);
    for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
  end
  assign sm_dataOut = pipe[LAT-2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int err_cnt = 0;
  always @(negedge clk) if (frame_err) err_cnt <= err_cnt + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  logic [WS-1:0] lg [N];
  int            acc_cyc;
  bit            aborted;

  function automatic logic [WS-1:0] exp_w(input int i);
    return lg[i] + WS'(3);
  endfunction

  task automatic load_base();
    lg = '{16'h00C4, 16'hFF5B, 16'h00D6, 16'h00EA, 16'hFE09,
           16'hFED9, 16'hFF29, 16'h0145, 16'hFF0C, 16'hFEC1};
  endtask

  task automatic run_frame(input bit gap, input int stall_idx,
                           input logic [N-1:0] last_mask, input int exp_err,
                           input bit hold, input int abort_idx,
                           input int exp_am);
    vec_t expv;
    int   err0;
    for (int i = 0; i < N; i++) expv[i] = lg[i];
    err0    = err_cnt;
    aborted = 1'b0;
    fork
      begin : prod
        int w;
        for (int i = 0; i < N; i++) begin
          if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
          end
          in_valid = 1'b1;
          in_data  = lg[i];
          in_last  = last_mask[i];
          w = 0;
          while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
          end
          check("in_ready_fill", in_ready, 1);
          @(posedge clk);
          @(negedge clk);
          acc_cyc = cyc;
        end
        in_valid = hold;
        in_data  = 16'h7777;
        in_last  = 1'b0;
      end
      begin : cons
        int got, guard, stall_left, first_c, last_c, sm_bad, busy_bad;
        bit seen;
        got = 0; guard = 0; seen = 0; first_c = 0; last_c = 0;
        sm_bad = 0; busy_bad = 0;
        stall_left = (stall_idx >= 0) ? 3 : 0;
        out_ready = 1'b1;
        while (got < N && guard < 300 && !aborted) begin
          @(negedge clk);
          guard++;
          if (busy && in_ready) busy_bad++;
          if (busy && sm_dataIn != expv) sm_bad++;
          if (out_valid) begin
            if (!seen) begin
              seen = 1;
              first_c = cyc;
              check("first_valid_lat", cyc - acc_cyc, LAT);
            end
            last_c = cyc;
            check("out_index", out_index, got);
            check("out_data", out_data, exp_w(got));
            check("out_last", out_last, got == N - 1);
            if (got == abort_idx) begin
              reset = 1'b1;
              #1;
              check("abort_out_valid", out_valid, 0);
              check("abort_out_data", out_data, 0);
              check("abort_out_index", out_index, 0);
              check("abort_out_last", out_last, 0);
              check("abort_busy", busy, 0);
              check("abort_in_ready", in_ready, 0);
              check("abort_sm_zero", sm_dataIn == '0, 1);
              @(negedge clk);
              reset    = 1'b0;
              in_valid = 1'b0;
              aborted  = 1'b1;
            end else if (got == stall_idx && stall_left > 0) begin
              out_ready = 1'b0;
              stall_left--;
            end else begin
              out_ready = 1'b1;
              got++;
            end
          end
        end
        if (!aborted) begin
          check("drain_words", got, N);
          check("drain_span", last_c - first_c + 1,
                N + ((stall_idx >= 0) ? 3 : 0));
          check("sm_hold_bad", sm_bad, 0);
          check("in_ready_busy_bad", busy_bad, 0);
          @(negedge clk);
          in_valid = 1'b0;
          check("in_ready_after", in_ready, 1);
          check("out_valid_after", out_valid, 0);
          check("busy_after", busy, 0);
          check("frame_err_pulses", err_cnt - err0, exp_err);
`ifdef SOFTMAX_ARGMAX_EN
          check("argmax_valid", argmax_valid, 1);
          check("argmax_idx", argmax_idx, exp_am);
          @(negedge clk);
          check("argmax_valid_pulse", argmax_valid, 0);
          check("argmax_idx_hold", argmax_idx, exp_am);
`else
          if (exp_am < 0) check("argmax_arg", exp_am, 0);
`endif
        end
      end
    join
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_sm_zero", sm_dataIn == '0, 1);
`ifdef SOFTMAX_ARGMAX_EN
    check("rst_argmax_valid", argmax_valid, 0);
    check("rst_argmax_idx", argmax_idx, 0);
`endif
    reset = 1'b0;

    load_base();
    run_frame(0, -1, 10'b10_0000_0000, 0, 0, -1, 7);
    run_frame(1, 4, 10'b10_0000_0000, 0, 0, -1, 7);
    run_frame(0, -1, 10'b10_0000_1000, 1, 0, -1, 7);
    run_frame(0, -1, 10'b00_0000_0000, 1, 1, -1, 7);
    run_frame(0, -1, 10'b10_0000_0000, 0, 0, 5, 7);
    lg[2] = 16'h0300;
    lg[6] = 16'h0300;
    run_frame(0, -1, 10'b10_0000_0000, 0, 0, -1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
